mult_arbiter: RTL and testbench

Round-robin arbiter that shares one `mult` instance among `NUM_REQ` independent requesters. Each requester presents an operand pair with a valid/ready handshake. The arbiter grants one pair, registers the operands, computes the product through the shared multiplier, and presents the tagged result on a single backpressured output port. It sits between the requesting datapaths and the single multiplier resource.

---
 rtl/mult_arbiter.sv | 154 +++++++++++++++
 tb/tb_mult_arbiter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_arbiter.sv
// Round-robin front end that shares one multiplier among NUM_REQ requesters and
// returns each tagged product on a single backpressured output port.

module mult #(
    parameter int INPUT_WIDTH = 8,
    parameter bit IS_SIGNED   = 1'b0
) (
    input  logic [INPUT_WIDTH-1:0]   a_i,
    input  logic [INPUT_WIDTH-1:0]   b_i,
    output logic [2*INPUT_WIDTH-1:0] p_o
);
    generate
        if (IS_SIGNED) begin : g_signed
            logic signed [2*INPUT_WIDTH-1:0] a_ext_s;
            logic signed [2*INPUT_WIDTH-1:0] b_ext_s;
            assign a_ext_s = {{INPUT_WIDTH{a_i[INPUT_WIDTH-1]}}, a_i};
            assign b_ext_s = {{INPUT_WIDTH{b_i[INPUT_WIDTH-1]}}, b_i};
            assign p_o     = a_ext_s * b_ext_s;
        end else begin : g_unsigned
            logic [2*INPUT_WIDTH-1:0] a_ext_s;
            logic [2*INPUT_WIDTH-1:0] b_ext_s;
            assign a_ext_s = {{INPUT_WIDTH{1'b0}}, a_i};
            assign b_ext_s = {{INPUT_WIDTH{1'b0}}, b_i};
            assign p_o     = a_ext_s * b_ext_s;
        end
    endgenerate
endmodule

module mult_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int INPUT_WIDTH = 8,
    parameter bit IS_SIGNED   = 1'b0,
    parameter int ID_WIDTH    = $clog2(NUM_REQ)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*INPUT_WIDTH-1:0] req_in0,
    input  logic [NUM_REQ*INPUT_WIDTH-1:0] req_in1,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [2*INPUT_WIDTH-1:0]       out_product,
    output logic [ID_WIDTH-1:0]            out_id
);
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COMPUTE = 2'd1,
        S_DONE    = 2'd2
    } state_e;

    state_e                    state_q;
    state_e                    state_d;
    logic [ID_WIDTH-1:0]       ptr_q;
    logic [INPUT_WIDTH-1:0]    op0_q;
    logic [INPUT_WIDTH-1:0]    op1_q;
    logic [ID_WIDTH-1:0]       gid_q;
    logic [2*INPUT_WIDTH-1:0]  out_product_q;
    logic [ID_WIDTH-1:0]       out_id_q;
    logic                      grant_found_s;
    logic [ID_WIDTH-1:0]       grant_idx_s;
    logic [2*INPUT_WIDTH-1:0]  product_s;

    function automatic logic [ID_WIDTH-1:0] wrap_idx(input int v);
        return ID_WIDTH'(v % NUM_REQ);
    endfunction

    mult #(
        .INPUT_WIDTH (INPUT_WIDTH),
        .IS_SIGNED   (IS_SIGNED)
    ) u_mult (
        .a_i (op0_q),
        .b_i (op1_q),
        .p_o (product_s)
    );

    // Round-robin search: first valid requester at or above ptr, wrapping to 0.
    always_comb begin
        grant_found_s = 1'b0;
        grant_idx_s   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!grant_found_s && req_valid[wrap_idx(int'(ptr_q) + k)]) begin
                grant_found_s = 1'b1;
                grant_idx_s   = wrap_idx(int'(ptr_q) + k);
            end else begin
                grant_found_s = grant_found_s;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    state_d = grant_found_s ? S_COMPUTE : S_IDLE;
            S_COMPUTE: state_d = S_DONE;
            S_DONE:    state_d = out_ready ? S_IDLE : S_DONE;
            default:   state_d = S_IDLE;
        endcase
    end

    // FSM outputs; the grant is masked by rst_n so nothing is accepted while held in reset.
    always_comb begin
        req_ready = '0;
        out_valid = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (grant_found_s && rst_n) begin
                    req_ready[grant_idx_s] = 1'b1;
                end else begin
                    req_ready = '0;
                end
            end
            S_DONE:  out_valid = 1'b1;
            default: out_valid = 1'b0;
        endcase
    end

    // Operand capture on accept, result capture after the compute cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q         <= '0;
            op0_q         <= '0;
            op1_q         <= '0;
            gid_q         <= '0;
            out_product_q <= '0;
            out_id_q      <= '0;
        end else begin
            if (state_q == S_IDLE && grant_found_s) begin
                op0_q <= req_in0[grant_idx_s*INPUT_WIDTH +: INPUT_WIDTH];
                op1_q <= req_in1[grant_idx_s*INPUT_WIDTH +: INPUT_WIDTH];
                gid_q <= grant_idx_s;
                ptr_q <= wrap_idx(int'(grant_idx_s) + 1);
            end
            if (state_q == S_COMPUTE) begin
                out_product_q <= product_s;
                out_id_q      <= gid_q;
            end
        end
    end

    assign out_product = out_product_q;
    assign out_id      = out_id_q;

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed and randomized bench for mult_arbiter: an unsigned and a signed instance
// share all inputs so each transaction checks both arithmetic modes.

module tb_mult_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [31:0] req_in0;
    logic [31:0] req_in1;
    logic        out_ready;
    logic [3:0]  req_ready_u, req_ready_s;
    logic        out_valid_u, out_valid_s;
    logic [15:0] out_product_u, out_product_s;
    logic [1:0]  out_id_u, out_id_s;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int bptr   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mult_arbiter #(.NUM_REQ(4), .INPUT_WIDTH(8), .IS_SIGNED(1'b0)) dut_u (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_in0(req_in0),
        .req_in1(req_in1), .req_ready(req_ready_u), .out_valid(out_valid_u),
        .out_ready(out_ready), .out_product(out_product_u), .out_id(out_id_u)
    );

    mult_arbiter #(.NUM_REQ(4), .INPUT_WIDTH(8), .IS_SIGNED(1'b1)) dut_s (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_in0(req_in0),
        .req_in1(req_in1), .req_ready(req_ready_s), .out_valid(out_valid_s),
        .out_ready(out_ready), .out_product(out_product_s), .out_id(out_id_s)
    );

    task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b);
        req_in0[i*8 +: 8] = a;
        req_in1[i*8 +: 8] = b;
    endtask

    function automatic int exp_grant(input logic [3:0] m, input int p);
        int r = -1;
        for (int k = 0; k < 4; k++) begin
            if (r < 0 && m[(p + k) % 4]) r = (p + k) % 4;
        end
        return r;
    endfunction

    // Polls each cycle (at negedge+1) for a grant; returns in the accept cycle.
    task automatic wait_accept(output logic [3:0] rdy, output int c, output bit to);
        to = 1'b1; rdy = 4'b0000; c = 0;
        for (int n = 0; n < 40; n++) begin
            if (n != 0) begin @(negedge clk); #1; end
            if (req_ready_u != 4'b0000) begin
                rdy = req_ready_u; c = cyc; to = 1'b0;
                break;
            end
        end
    endtask

    // Polls each cycle for out_valid; returns in the first DONE cycle.
    task automatic wait_out(output logic [15:0] pu, output logic [15:0] ps,
                            output logic [1:0] id, output int c, output bit to);
        to = 1'b1; pu = 16'h0000; ps = 16'h0000; id = 2'd0; c = 0;
        for (int n = 0; n < 40; n++) begin
            if (n != 0) begin @(negedge clk); #1; end
            if (out_valid_u) begin
                pu = out_product_u; ps = out_product_s; id = out_id_u; c = cyc; to = 1'b0;
                break;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; req_valid = 4'b0000; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bptr = 0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0; req_valid = 4'b1111; #1;
        checks++; if (req_ready_u !== 4'b0000) begin errors++; $display("FAIL reset_ready: got %b want 0000", req_ready_u); end
        checks++; if (req_ready_s !== 4'b0000) begin errors++; $display("FAIL reset_ready_s: got %b want 0000", req_ready_s); end
        checks++; if (out_valid_u !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid_u); end
        checks++; if (out_product_u !== 16'h0000) begin errors++; $display("FAIL reset_product: got %h want 0000", out_product_u); end
        checks++; if (out_id_u !== 2'd0) begin errors++; $display("FAIL reset_id: got %0d want 0", out_id_u); end
        @(negedge clk);
        rst_n = 1'b1; req_valid = 4'b0000;
    endtask

    task automatic test_single();
        logic [3:0] rdy; logic [15:0] pu, ps; logic [1:0] id; int c0, c1; bit to;
        @(negedge clk);
        req_valid = 4'b0100; set_op(2, 8'd200, 8'd3); out_ready = 1'b1; #1;
        wait_accept(rdy, c0, to);
        checks++; if (to || rdy !== 4'b0100) begin errors++; $display("FAIL single_grant: got %b to=%0d want 0100", rdy, to); end
        @(negedge clk); req_valid = 4'b0000; #1;
        wait_out(pu, ps, id, c1, to);
        checks++; if (to || (c1 - c0) !== 2) begin errors++; $display("FAIL single_latency: got %0d to=%0d want 2", c1 - c0, to); end
        checks++; if (pu !== 16'd600) begin errors++; $display("FAIL single_product: got %0d want 600", pu); end
        checks++; if (id !== 2'd2) begin errors++; $display("FAIL single_id: got %0d want 2", id); end
        checks++; if (ps !== 16'hFF58) begin errors++; $display("FAIL single_signed_product: got %h want ff58", ps); end
    endtask

    task automatic test_all_four();
        logic [3:0] rdy; logic [15:0] pu, ps; logic [1:0] id; int c0, c1, prev; bit to;
        int g; logic [15:0] ep;
        do_reset();
        for (int i = 0; i < 4; i++) set_op(i, 8'(10 * (i + 1)), 8'(7 + i));
        req_valid = 4'b1111; out_ready = 1'b1; #1;
        prev = 0;
        for (int k = 0; k < 5; k++) begin
            g = k % 4;
            ep = 16'((10 * (g + 1)) * (7 + g));
            wait_accept(rdy, c0, to);
            checks++; if (to || rdy !== 4'(1 << g)) begin errors++; $display("FAIL rr_grant[%0d]: got %b want %b", k, rdy, 4'(1 << g)); end
            if (k > 0) begin
                checks++; if ((c0 - prev) !== 3) begin errors++; $display("FAIL rr_interval[%0d]: got %0d want 3", k, c0 - prev); end
            end
            prev = c0;
            wait_out(pu, ps, id, c1, to);
            checks++; if (to || id !== 2'(g)) begin errors++; $display("FAIL rr_id[%0d]: got %0d want %0d", k, id, g); end
            checks++; if (pu !== ep || ps !== ep) begin errors++; $display("FAIL rr_product[%0d]: got %0d/%0d want %0d", k, pu, ps, ep); end
        end
    endtask

    task automatic test_ptr_wrap();
        logic [3:0] masks [4] = '{4'b1000, 4'b1010, 4'b1010, 4'b0101};
        int         grants[4] = '{3, 1, 3, 0};
        logic [3:0] rdy; logic [15:0] pu, ps; logic [1:0] id; int c0, c1; bit to;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); req_valid = masks[k]; #1;
            wait_accept(rdy, c0, to);
            checks++; if (to || rdy !== 4'(1 << grants[k])) begin errors++; $display("FAIL wrap_grant[%0d]: got %b want %b", k, rdy, 4'(1 << grants[k])); end
            wait_out(pu, ps, id, c1, to);
            checks++; if (to || id !== 2'(grants[k])) begin errors++; $display("FAIL wrap_id[%0d]: got %0d want %0d", k, id, grants[k]); end
        end
    endtask

    task automatic test_backpressure();
        logic [3:0] rdy; logic [15:0] pu, ps; logic [1:0] id; int c0, c1, hc; bit to;
        @(negedge clk);
        out_ready = 1'b0; req_valid = 4'b0001; #1;
        wait_accept(rdy, c0, to);
        checks++; if (to || rdy !== 4'b0001) begin errors++; $display("FAIL bp_first_grant: got %b want 0001", rdy); end
        @(negedge clk); req_valid = 4'b0010; #1;
        wait_out(pu, ps, id, c1, to);
        checks++; if (to) begin errors++; $display("FAIL bp_out_timeout: got none want out_valid"); end
        for (int j = 0; j < 10; j++) begin
            checks++;
            if (out_valid_u !== 1'b1 || out_product_u !== 16'd70 || out_id_u !== 2'd0 || req_ready_u !== 4'b0000) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got v=%b p=%0d id=%0d rdy=%b want v=1 p=70 id=0 rdy=0000",
                         j, out_valid_u, out_product_u, out_id_u, req_ready_u);
            end
            @(negedge clk); #1;
        end
        out_ready = 1'b1; hc = cyc;
        checks++; if (out_valid_u !== 1'b1 || req_ready_u !== 4'b0000) begin errors++; $display("FAIL bp_release: got v=%b rdy=%b want v=1 rdy=0000", out_valid_u, req_ready_u); end
        @(negedge clk); #1;
        wait_accept(rdy, c0, to);
        checks++; if (to || rdy !== 4'b0010 || c0 !== hc + 1) begin errors++; $display("FAIL bp_next_accept: got %b at +%0d want 0010 at +1", rdy, c0 - hc); end
        @(negedge clk); req_valid = 4'b0000; #1;
        wait_out(pu, ps, id, c1, to);
        checks++; if (to || id !== 2'd1 || pu !== 16'd160) begin errors++; $display("FAIL bp_second_result: got id=%0d p=%0d want id=1 p=160", id, pu); end
    endtask

    task automatic test_signed();
        logic [3:0] rdy; logic [15:0] pu, ps; logic [1:0] id; int c0, c1; bit to;
        out_ready = 1'b1;
        @(negedge clk); set_op(2, 8'hFD, 8'h05); req_valid = 4'b0100; #1;
        wait_accept(rdy, c0, to);
        checks++; if (to || rdy !== 4'b0100) begin errors++; $display("FAIL signed_grant_a: got %b want 0100", rdy); end
        @(negedge clk); req_valid = 4'b0000; #1;
        wait_out(pu, ps, id, c1, to);
        checks++; if (to || ps !== 16'hFFF1) begin errors++; $display("FAIL signed_neg: got %h want fff1", ps); end
        checks++; if (pu !== 16'd1265) begin errors++; $display("FAIL unsigned_fd: got %0d want 1265", pu); end
        @(negedge clk); set_op(3, 8'h80, 8'h80); req_valid = 4'b1000; #1;
        wait_accept(rdy, c0, to);
        checks++; if (to || rdy !== 4'b1000) begin errors++; $display("FAIL signed_grant_b: got %b want 1000", rdy); end
        @(negedge clk); req_valid = 4'b0000; #1;
        wait_out(pu, ps, id, c1, to);
        checks++; if (to || ps !== 16'h4000) begin errors++; $display("FAIL signed_min: got %h want 4000", ps); end
        checks++; if (pu !== 16'h4000) begin errors++; $display("FAIL unsigned_80: got %h want 4000", pu); end
    endtask

    task automatic test_reset_midop();
        logic [3:0] rdy; logic [15:0] pu, ps; logic [1:0] id; int c0, c1; bit to;
        out_ready = 1'b1;
        @(negedge clk); req_valid = 4'b0100; #1;
        wait_accept(rdy, c0, to);
        checks++; if (to || rdy !== 4'b0100) begin errors++; $display("FAIL midop_grant: got %b want 0100", rdy); end
        @(negedge clk); rst_n = 1'b0; req_valid = 4'b1111; #1;
        for (int j = 0; j < 3; j++) begin
            checks++;
            if (out_valid_u !== 1'b0 || out_valid_s !== 1'b0 || req_ready_u !== 4'b0000 || out_product_u !== 16'h0000) begin
                errors++;
                $display("FAIL midop_in_reset[%0d]: got v=%b rdy=%b p=%h want v=0 rdy=0000 p=0000", j, out_valid_u, req_ready_u, out_product_u);
            end
            @(negedge clk); #1;
        end
        rst_n = 1'b1; req_valid = 4'b1010; #1;
        checks++; if (out_valid_u !== 1'b0) begin errors++; $display("FAIL midop_after_release: got v=%b want 0", out_valid_u); end
        wait_accept(rdy, c0, to);
        checks++; if (to || rdy !== 4'b0010) begin errors++; $display("FAIL midop_first_grant: got %b want 0010", rdy); end
        @(negedge clk); req_valid = 4'b0000; #1;
        wait_out(pu, ps, id, c1, to);
        checks++; if (to || id !== 2'd1 || pu !== 16'd160) begin errors++; $display("FAIL midop_result: got id=%0d p=%0d want id=1 p=160", id, pu); end
    endtask

    task automatic test_random();
        logic [3:0] rdy, mask, em; logic [15:0] pu, ps; logic [1:0] id; int c0, c1; bit to;
        int eg; logic [7:0] a, b; logic [15:0] exp_u; logic signed [15:0] exp_s; bit r;
        do_reset();
        for (int it = 0; it < 1000; it++) begin
            @(negedge clk);
            mask = 4'($urandom_range(1, 15));
            for (int i = 0; i < 4; i++) set_op(i, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
            req_valid = mask; out_ready = 1'b0; #1;
            eg = exp_grant(mask, bptr);
            em = 4'(1 << eg);
            a = req_in0[eg*8 +: 8];
            b = req_in1[eg*8 +: 8];
            exp_u = {8'h00, a} * {8'h00, b};
            exp_s = $signed({{8{a[7]}}, a}) * $signed({{8{b[7]}}, b});
            wait_accept(rdy, c0, to);
            checks++; if (to || rdy !== em || req_ready_s !== em) begin errors++; $display("FAIL rand_grant[%0d]: got %b/%b want %b", it, rdy, req_ready_s, em); end
            bptr = (eg + 1) % 4;
            @(negedge clk); req_valid = 4'($urandom_range(0, 15)); #1;
            wait_out(pu, ps, id, c1, to);
            checks++;
            if (to || pu !== exp_u || ps !== exp_s || id !== 2'(eg) || out_id_s !== 2'(eg)) begin
                errors++;
                $display("FAIL rand_result[%0d]: got u=%h s=%h id=%0d want u=%h s=%h id=%0d", it, pu, ps, id, exp_u, exp_s, eg);
            end
            for (int h = 0; h < 20; h++) begin
                r = (h == 19) ? 1'b1 : 1'($urandom_range(0, 1));
                out_ready = r;
                checks++;
                if (out_valid_u !== 1'b1 || out_product_u !== exp_u || req_ready_u !== 4'b0000) begin
                    errors++;
                    $display("FAIL rand_hold[%0d]: got v=%b p=%h rdy=%b want v=1 p=%h rdy=0000", it, out_valid_u, out_product_u, req_ready_u, exp_u);
                end
                if (r) break;
                @(negedge clk); #1;
            end
        end
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: got no completion want finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; req_valid = 4'b0000; req_in0 = 32'h0; req_in1 = 32'h0; out_ready = 1'b0;
        test_reset();
        test_single();
        test_all_four();
        test_ptr_wrap();
        test_backpressure();
        test_signed();
        test_reset_midop();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
